// File: rtl/pc_unit_stack_if.sv
// Control-side bundle for the program-counter unit: mode/enable/data in,
// PC, lagged PC, stack pointer and stack status flags out.
interface pc_unit_stack_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           en;
  logic [2:0]     m;
  logic [W-1:0]   data_in;
  logic [W-1:0]   pc;
  logic [W-1:0]   y;
  logic [SPW-1:0] sp;
  logic           stk_full;
  logic           stk_empty;
  logic           ovf;
  logic           udf;

  modport master (
    output en, m, data_in,
    input  pc, y, sp, stk_full, stk_empty, ovf, udf
  );

  modport slave (
    input  en, m, data_in,
    output pc, y, sp, stk_full, stk_empty, ovf, udf
  );
endinterface

// File: rtl/pc_unit_stack.sv
// Program counter with inc/dec/load/hold/relative branch and call/return
// through a LIFO return-address stack; all state advances on the falling edge.
module pc_unit_stack #(
  parameter int           W         = 8,
  parameter int           DEPTH     = 4,
  parameter logic [W-1:0] RESET_VEC = '0
) (
  input  logic           clk,
  input  logic           clr_n,
  pc_unit_stack_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  typedef enum logic [2:0] {
    M_INC  = 3'b000,
    M_DEC  = 3'b001,
    M_LOAD = 3'b010,
    M_HOLD = 3'b011,
    M_BREL = 3'b100,
    M_CALL = 3'b101,
    M_RET  = 3'b110,
    M_INC2 = 3'b111
  } mode_t;

  logic [W-1:0]   r_pc;
  logic [W-1:0]   r_y;
  logic [SPW-1:0] r_sp;
  logic           r_ovf;
  logic           r_udf;
  logic [W-1:0]   r_stack [DEPTH];

  mode_t          w_mode;
  logic [W-1:0]   w_pc_nxt;
  logic [W-1:0]   w_ret_addr;
  logic [SPW-1:0] w_sp_nxt;
  logic           w_push;
  logic           w_ovf_set;
  logic           w_udf_set;
  logic           w_full;
  logic           w_empty;
  logic [AW-1:0]  w_push_idx;
  logic [AW-1:0]  w_top_idx;
  logic signed [W-1:0] w_pc_s;
  logic signed [W-1:0] w_off;

  assign w_mode     = mode_t'(bus.m);
  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_ret_addr = r_pc + W'(1);
  // Low bits of sp address the next free slot; only used when not full.
  assign w_push_idx = r_sp[AW-1:0];
  assign w_top_idx  = w_push_idx - AW'(1);
  assign w_pc_s     = $signed(r_pc);
  assign w_off      = $signed(bus.data_in);

  always_comb begin
    w_pc_nxt  = r_pc + W'(1);
    w_sp_nxt  = r_sp;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    case (w_mode)
      M_DEC:  w_pc_nxt = r_pc - W'(1);
      M_LOAD: w_pc_nxt = bus.data_in;
      M_HOLD: w_pc_nxt = r_pc;
      M_BREL: w_pc_nxt = $unsigned(w_pc_s + w_off);
      M_CALL: begin
        // The jump is taken even when the push is refused.
        w_pc_nxt = bus.data_in;
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_push   = 1'b1;
          w_sp_nxt = r_sp + SPW'(1);
        end
      end
      M_RET: begin
        if (w_empty) begin
          w_udf_set = 1'b1;
        end else begin
          w_pc_nxt = r_stack[w_top_idx];
          w_sp_nxt = r_sp - SPW'(1);
        end
      end
      default: w_pc_nxt = r_pc + W'(1);
    endcase
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pc  <= RESET_VEC;
      r_y   <= '0;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (bus.en) begin
      r_pc <= w_pc_nxt;
      r_y  <= r_pc;
      r_sp <= w_sp_nxt;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_udf_set) r_udf <= 1'b1;
    end
  end

  // Stack contents are don't-care after reset, so the storage has no reset.
  always_ff @(negedge clk) begin
    if (bus.en && w_push) r_stack[w_push_idx] <= w_ret_addr;
  end

  assign bus.pc        = r_pc;
  assign bus.y         = r_y;
  assign bus.sp        = r_sp;
  assign bus.stk_full  = w_full;
  assign bus.stk_empty = w_empty;
  assign bus.ovf       = r_ovf;
  assign bus.udf       = r_udf;
endmodule

// File: tb/tb_pc_unit_stack.sv
// Bench for pc_unit_stack (W=8, DEPTH=4, RESET_VEC=0): directed scenarios plus
// a behavioural-model scoreboard checked after every falling edge.
module tb_pc_unit_stack;
  logic clk;
  logic clr_n;
  int   checks;
  int   errors;

  pc_unit_stack_if #(.W(8), .DEPTH(4)) bus ();

  pc_unit_stack #(.W(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] y;
    logic [2:0] sp;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] mpc, my;
  logic [2:0] msp;
  logic [7:0] mstk [4];
  logic       movf, mudf;

  task automatic model_reset();
    mpc = 8'h00; my = 8'h00; msp = 3'd0; movf = 1'b0; mudf = 1'b0;
    q.delete();
  endtask

  // Drive one cycle, predict the post-edge state, queue it, step past the edge.
  task automatic apply(input logic e, input logic [2:0] mm, input logic [7:0] d);
    logic [7:0] nxt;
    bus.en = e; bus.m = mm; bus.data_in = d;
    if (e) begin
      nxt = mpc + 8'd1;
      case (mm)
        3'd1: nxt = mpc - 8'd1;
        3'd2: nxt = d;
        3'd3: nxt = mpc;
        3'd4: nxt = 8'(mpc + d);
        3'd5: begin
          nxt = d;
          if (msp == 3'd4) movf = 1'b1;
          else begin mstk[int'(msp)] = mpc + 8'd1; msp = msp + 3'd1; end
        end
        3'd6: begin
          if (msp == 3'd0) mudf = 1'b1;
          else begin msp = msp - 3'd1; nxt = mstk[int'(msp)]; end
        end
        default: nxt = mpc + 8'd1;
      endcase
      my  = mpc;
      mpc = nxt;
    end
    q.push_back('{pc: mpc, y: my, sp: msp, ovf: movf, udf: mudf});
    @(negedge clk); #2;
  endtask

  always @(negedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (bus.pc !== mon_e.pc || bus.y !== mon_e.y || bus.sp !== mon_e.sp ||
          bus.ovf !== mon_e.ovf || bus.udf !== mon_e.udf) begin
        errors++;
        $display("FAIL scoreboard_state t=%0t got pc=%h y=%h sp=%0d ovf=%b udf=%b exp pc=%h y=%h sp=%0d ovf=%b udf=%b",
                 $time, bus.pc, bus.y, bus.sp, bus.ovf, bus.udf,
                 mon_e.pc, mon_e.y, mon_e.sp, mon_e.ovf, mon_e.udf);
      end
      checks++;
      if (bus.stk_full !== (mon_e.sp == 3'd4) || bus.stk_empty !== (mon_e.sp == 3'd0)) begin
        errors++;
        $display("FAIL scoreboard_flags t=%0t got full=%b empty=%b exp full=%b empty=%b",
                 $time, bus.stk_full, bus.stk_empty, mon_e.sp == 3'd4, mon_e.sp == 3'd0);
      end
    end
  end

  task automatic do_reset();
    clr_n = 1'b0;
    model_reset();
    @(negedge clk); #2;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; bus.en = 1'b0; bus.m = 3'd0; bus.data_in = 8'h00;
    model_reset();
    #3;
    checks++;
    if (bus.pc !== 8'h00 || bus.y !== 8'h00 || bus.sp !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs got pc=%h y=%h sp=%0d exp 00 00 0", bus.pc, bus.y, bus.sp);
    end
    checks++;
    if (bus.ovf !== 1'b0 || bus.udf !== 1'b0 || bus.stk_empty !== 1'b1 || bus.stk_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got ovf=%b udf=%b empty=%b full=%b exp 0 0 1 0",
               bus.ovf, bus.udf, bus.stk_empty, bus.stk_full);
    end
    @(negedge clk); #2;
    clr_n = 1'b1;
  endtask

  task automatic test_inc();
    logic [7:0] exp_pc [3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] exp_y  [3] = '{8'h00, 8'h01, 8'h02};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'd0, 8'h00);
      checks++;
      if (bus.pc !== exp_pc[i] || bus.y !== exp_y[i]) begin
        errors++;
        $display("FAIL inc_step%0d got pc=%h y=%h exp pc=%h y=%h", i, bus.pc, bus.y, exp_pc[i], exp_y[i]);
      end
    end
    // Asynchronous reset between edges: clock is low and stays so.
    clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.pc !== 8'h00 || bus.y !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got pc=%h y=%h exp 00 00", bus.pc, bus.y);
    end
    #1;
    clr_n = 1'b1;
    apply(1'b1, 3'd0, 8'h00);
    checks++;
    if (bus.pc !== 8'h01) begin
      errors++;
      $display("FAIL post_reset_inc got pc=%h exp 01", bus.pc);
    end
  endtask

  task automatic test_wrap_brel();
    apply(1'b1, 3'd2, 8'hFE);
    apply(1'b1, 3'd0, 8'h00);
    checks++;
    if (bus.pc !== 8'hFF) begin errors++; $display("FAIL wrap_ff got pc=%h exp ff", bus.pc); end
    apply(1'b1, 3'd0, 8'h00);
    checks++;
    if (bus.pc !== 8'h00 || bus.y !== 8'hFF) begin
      errors++; $display("FAIL wrap_00 got pc=%h y=%h exp 00 ff", bus.pc, bus.y);
    end
    apply(1'b1, 3'd2, 8'h10);
    apply(1'b1, 3'd4, 8'hF0);
    checks++;
    if (bus.pc !== 8'h00) begin errors++; $display("FAIL brel_neg got pc=%h exp 00", bus.pc); end
    apply(1'b1, 3'd4, 8'h05);
    checks++;
    if (bus.pc !== 8'h05) begin errors++; $display("FAIL brel_pos got pc=%h exp 05", bus.pc); end
    apply(1'b1, 3'd2, 8'h00);
    apply(1'b1, 3'd1, 8'h00);
    checks++;
    if (bus.pc !== 8'hFF) begin errors++; $display("FAIL dec_wrap got pc=%h exp ff", bus.pc); end
    apply(1'b1, 3'd7, 8'h00);
    checks++;
    if (bus.pc !== 8'h00) begin errors++; $display("FAIL inc_alt got pc=%h exp 00", bus.pc); end
  endtask

  task automatic test_call_ret();
    apply(1'b1, 3'd2, 8'h20);
    apply(1'b1, 3'd5, 8'h40);
    checks++;
    if (bus.pc !== 8'h40 || bus.sp !== 3'd1) begin
      errors++; $display("FAIL call1 got pc=%h sp=%0d exp 40 1", bus.pc, bus.sp);
    end
    apply(1'b1, 3'd5, 8'h60);
    checks++;
    if (bus.pc !== 8'h60 || bus.sp !== 3'd2) begin
      errors++; $display("FAIL call2 got pc=%h sp=%0d exp 60 2", bus.pc, bus.sp);
    end
    apply(1'b1, 3'd6, 8'h00);
    checks++;
    if (bus.pc !== 8'h41 || bus.sp !== 3'd1) begin
      errors++; $display("FAIL ret1 got pc=%h sp=%0d exp 41 1", bus.pc, bus.sp);
    end
    apply(1'b1, 3'd6, 8'h00);
    checks++;
    if (bus.pc !== 8'h21 || bus.sp !== 3'd0 || bus.stk_empty !== 1'b1) begin
      errors++; $display("FAIL ret2 got pc=%h sp=%0d empty=%b exp 21 0 1", bus.pc, bus.sp, bus.stk_empty);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ret_exp [4] = '{8'h31, 8'h21, 8'h11, 8'h01};
    apply(1'b1, 3'd2, 8'h00);
    apply(1'b1, 3'd5, 8'h10);
    apply(1'b1, 3'd5, 8'h20);
    apply(1'b1, 3'd5, 8'h30);
    apply(1'b1, 3'd5, 8'h40);
    checks++;
    if (bus.stk_full !== 1'b1 || bus.sp !== 3'd4 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL full got full=%b sp=%0d ovf=%b exp 1 4 0", bus.stk_full, bus.sp, bus.ovf);
    end
    apply(1'b1, 3'd5, 8'h80);
    checks++;
    if (bus.pc !== 8'h80 || bus.sp !== 3'd4 || bus.ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_call got pc=%h sp=%0d ovf=%b exp 80 4 1", bus.pc, bus.sp, bus.ovf);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 3'd6, 8'h00);
      checks++;
      if (bus.pc !== ret_exp[i] || bus.ovf !== 1'b1) begin
        errors++; $display("FAIL ovf_ret%0d got pc=%h ovf=%b exp %h 1", i, bus.pc, bus.ovf, ret_exp[i]);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(1'b1, 3'd2, 8'h33);
    apply(1'b1, 3'd6, 8'h00);
    checks++;
    if (bus.pc !== 8'h34 || bus.udf !== 1'b1 || bus.sp !== 3'd0) begin
      errors++; $display("FAIL udf_ret got pc=%h udf=%b sp=%0d exp 34 1 0", bus.pc, bus.udf, bus.sp);
    end
    apply(1'b1, 3'd0, 8'h00);
    checks++;
    if (bus.pc !== 8'h35 || bus.udf !== 1'b1) begin
      errors++; $display("FAIL udf_sticky got pc=%h udf=%b exp 35 1", bus.pc, bus.udf);
    end
    do_reset();
    checks++;
    if (bus.udf !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL udf_clear got udf=%b ovf=%b exp 0 0", bus.udf, bus.ovf);
    end
  endtask

  task automatic test_enable_hold();
    logic [7:0] pc0, y0;
    apply(1'b1, 3'd2, 8'h5A);
    apply(1'b1, 3'd5, 8'h70);
    pc0 = mpc; y0 = my;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 3'($urandom_range(0, 7)), 8'($urandom));
      checks++;
      if (bus.pc !== 8'h70 || bus.y !== 8'h5A || bus.sp !== 3'd1) begin
        errors++; $display("FAIL en0_hold%0d got pc=%h y=%h sp=%0d exp 70 5a 1", i, bus.pc, bus.y, bus.sp);
      end
    end
    apply(1'b1, 3'd3, 8'hAA);
    checks++;
    if (bus.pc !== pc0 || bus.y !== pc0 || y0 !== 8'h5A) begin
      errors++; $display("FAIL hold_mode got pc=%h y=%h exp %h %h", bus.pc, bus.y, pc0, pc0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_inc();
    test_wrap_brel();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_enable_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
